// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath with a req/ack data-memory port.
// Define DATAPATH_TRAP_EN to halt on unrecognised opcodes; otherwise they retire as NOPs.
`ifndef OP_BR
`define OP_BR   5'd0
`define OP_ADD  5'd1
`define OP_LDW  5'd2
`define OP_STW  5'd3
`define OP_JSR  5'd4
`define OP_AND  5'd5
`define OP_JSRR 5'd6
`define OP_JMP  5'd12
`define OP_MOV  5'd13
`endif

module mc_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUM    = 8,
    parameter int PC_WIDTH   = 16,
    parameter int DMEM_AW    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock,
    output logic [PC_WIDTH-3:0]   imem_addr,
    input  logic [31:0]           imem_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DMEM_AW-1:0]    dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [2:0]            cc,
    output logic [2:0]            state,
    output logic                  halted
);
    localparam int RW = $clog2(REG_NUM);
`ifdef DATAPATH_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;

    state_t                st, st_nxt;
    logic [31:0]           ir;
    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [DATA_WIDTH-1:0] a, b, d, res, imm, opnd, alu;
    logic [DMEM_AW-1:0]    addr;
    logic [PC_WIDTH-1:0]   pc4, br_tgt;
    logic [4:0]            op;
    logic [RW-1:0]         wr_idx;
    logic                  is_alu, is_mem, known, taken, halt_r;
    logic                  unused_bits;

    assign op          = ir[31:27];
    assign imm         = DATA_WIDTH'($signed(ir[15:0]));
    assign opnd        = ir[24] ? imm : b;
    assign alu         = op == `OP_ADD ? a + opnd : op == `OP_AND ? a & opnd : opnd;
    assign is_alu      = op == `OP_ADD || op == `OP_AND || op == `OP_MOV;
    assign is_mem      = op == `OP_LDW || op == `OP_STW;
    assign known       = is_alu || is_mem || op == `OP_BR || op == `OP_JMP || op == `OP_JSR || op == `OP_JSRR;
    assign taken       = |(ir[26:24] & cc);
    assign pc4         = pc + PC_WIDTH'(4);
    assign br_tgt      = pc4 + PC_WIDTH'($signed({ir[15:0], 2'b00}));
    assign wr_idx      = ir[20 +: RW];
    assign unused_bits = ^{imem_data, ir};

    // Address/data outputs read as zero while reset is held, independent of the clock edge.
    assign state      = st;
    assign imem_addr  = reset ? '0 : pc[PC_WIDTH-1:2];
    assign dmem_req   = st == MEM;
    assign dmem_we    = st == MEM && op == `OP_STW;
    assign dmem_addr  = reset ? '0 : addr;
    assign dmem_wdata = reset ? '0 : d;
    assign halted     = TRAP && halt_r;

    always_ff @(posedge clk) begin
        if (reset) st <= FETCH;
        else st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        if (lock)
            case (st)
                FETCH:   st_nxt = DECODE;
                DECODE:  st_nxt = EXEC;
                EXEC:    st_nxt = is_alu ? WB : is_mem ? MEM : (known || !TRAP) ? FETCH : EXEC;
                MEM:     st_nxt = !dmem_ack ? MEM : op == `OP_LDW ? WB : FETCH;
                default: st_nxt = FETCH;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            cc     <= 3'b010;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            d      <= '0;
            res    <= '0;
            addr   <= '0;
            halt_r <= 1'b0;
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (lock) begin
            case (st)
                DECODE: begin
                    ir <= imem_data;
                    a  <= regs[imem_data[16 +: RW]];
                    b  <= regs[imem_data[8 +: RW]];
                    d  <= regs[imem_data[20 +: RW]];
                end
                EXEC: begin
                    res  <= alu;
                    addr <= DMEM_AW'(a + imm);
                    if (op == `OP_BR) pc <= taken ? br_tgt : pc4;
                    if (op == `OP_JMP) pc <= PC_WIDTH'(a);
                    if (op == `OP_JSR || op == `OP_JSRR) begin
                        regs[REG_NUM-1] <= DATA_WIDTH'(pc4);
                        pc              <= op == `OP_JSR ? br_tgt : PC_WIDTH'(a);
                    end
                    // A trapped instruction keeps its PC so the fault address stays visible.
                    if (!known) begin
                        if (TRAP) halt_r <= 1'b1;
                        else pc <= pc4;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        res <= dmem_rdata;
                        if (op == `OP_STW) pc <= pc4;
                    end
                end
                WB: begin
                    regs[wr_idx] <= res;
                    cc           <= res[DATA_WIDTH-1] ? 3'b100 : res == '0 ? 3'b010 : 3'b001;
                    pc           <= pc4;
                end
                default: ;
            endcase
        end
    end
endmodule
